// File: rtl/steer_if.sv
// Steering conditioner bus: raw pot sample in, conditioned steering term out.
//   vld/raw        : raw sample strobe and unsigned sample
//   en/bypass_slew : steering enable and slew-limiter bypass (sampled at output stage)
//   steer_out      : signed conditioned steering value
//   out_vld        : one-cycle pulse when steer_out updates
//   sat            : last accepted sample was clamped
//   settled        : steer_out equals current target
interface steer_if #(
  parameter int unsigned WIDTH = 12
);
  logic             vld;
  logic [WIDTH-1:0] raw;
  logic             en;
  logic             bypass_slew;
  logic [WIDTH-1:0] steer_out;
  logic             out_vld;
  logic             sat;
  logic             settled;

  // Source of raw samples / consumer of the steering term
  modport master (
    output vld, raw, en, bypass_slew,
    input  steer_out, out_vld, sat, settled
  );

  // The conditioner itself
  modport slave (
    input  vld, raw, en, bypass_slew,
    output steer_out, out_vld, sat, settled
  );
endinterface

// File: rtl/steer_cond.sv
// Steering-input conditioner: clamp -> moving average -> centre/deadband -> slew limit.
// Four register stages: vld sampled at edge N updates steer_out/out_vld at edge N+3.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   sif   : steer_if.slave (vld, raw, en, bypass_slew in; steer_out, out_vld, sat, settled out)
module steer_cond #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned CENTER    = 'h800,
  parameter int unsigned MIN_RAW   = 'h200,
  parameter int unsigned MAX_RAW   = 'hE00,
  parameter int unsigned AVG_LOG2  = 2,
  parameter int unsigned DEADBAND  = 16,
  parameter int unsigned SLEW_STEP = 64
) (
  input  logic   clk,
  input  logic   rst_n,
  steer_if.slave sif
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = WIDTH + AVG_LOG2;
  localparam int unsigned PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned DW    = WIDTH + 1;

  localparam logic [WIDTH-1:0]     C_CENTER = WIDTH'(CENTER);
  localparam logic [WIDTH-1:0]     C_MIN    = WIDTH'(MIN_RAW);
  localparam logic [WIDTH-1:0]     C_MAX    = WIDTH'(MAX_RAW);
  localparam logic [SUM_W-1:0]     C_SUM0   = SUM_W'(CENTER) << AVG_LOG2;
  localparam logic signed [DW-1:0] C_DB     = DW'(DEADBAND);
  localparam logic signed [DW-1:0] C_STEP   = DW'(SLEW_STEP);
  localparam logic [PTR_W-1:0]     C_PLAST  = PTR_W'(DEPTH - 1);

  // Elaboration-time parameter legality
  if (!((MIN_RAW <= CENTER) && (CENTER <= MAX_RAW))) begin : g_bad_center
    $error("steer_cond: CENTER must lie within [MIN_RAW, MAX_RAW]");
  end
  if ((MAX_RAW - CENTER > (2 ** (WIDTH - 1)) - 1) || (CENTER - MIN_RAW > 2 ** (WIDTH - 1))) begin : g_bad_span
    $error("steer_cond: clamp window does not fit signed WIDTH output");
  end
  if (AVG_LOG2 > 4) begin : g_bad_avg
    $error("steer_cond: AVG_LOG2 must be 0..4");
  end

  // Stage 1: clamp
  logic             r_s1_vld;
  logic [WIDTH-1:0] r_clamp;
  logic             r_sat;
  // Stage 2: moving-average accumulator
  logic [WIDTH-1:0] r_buf [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [SUM_W-1:0] r_sum;
  logic             r_s2_vld;
  // Stage 3: centred, deadbanded value (enable not yet applied)
  logic             r_s3_vld;
  logic signed [DW-1:0] r_t;
  // Stage 4: slew-limited output
  logic signed [WIDTH-1:0] r_steer;
  logic                    r_out_vld;
  logic                    r_settled;

  logic [WIDTH-1:0]     w_clamp;
  logic                 w_oor;
  logic [SUM_W-1:0]     w_sum_nxt;
  logic [WIDTH-1:0]     w_avg;
  logic signed [DW-1:0] w_d;
  logic signed [DW-1:0] w_abs_d;
  logic signed [DW-1:0] w_t;
  logic signed [DW-1:0] w_tgt;
  logic signed [DW-1:0] w_cur;
  logic signed [DW-1:0] w_diff;
  logic signed [DW-1:0] w_abs_diff;
  logic signed [DW-1:0] w_new;

  // Clamp raw sample into the legal window
  always_comb begin
    w_oor   = (sif.raw < C_MIN) || (sif.raw > C_MAX);
    w_clamp = sif.raw;
    if (sif.raw < C_MIN)      w_clamp = C_MIN;
    else if (sif.raw > C_MAX) w_clamp = C_MAX;
  end

  // Running sum: add newest, drop the entry being overwritten
  assign w_sum_nxt = r_sum + SUM_W'(r_clamp) - SUM_W'(r_buf[r_wptr]);

  // Average, re-centre and deadband
  always_comb begin
    w_avg   = WIDTH'(r_sum >> AVG_LOG2);
    w_d     = $signed({1'b0, w_avg}) - $signed({1'b0, C_CENTER});
    w_abs_d = (w_d < 0) ? -w_d : w_d;
    w_t     = (w_abs_d <= C_DB) ? '0 : w_d;
  end

  // Enable gating and slew limiting; window legality guarantees DW bits suffice
  always_comb begin
    w_tgt      = sif.en ? r_t : '0;
    w_cur      = {r_steer[WIDTH-1], r_steer};
    w_diff     = w_tgt - w_cur;
    w_abs_diff = (w_diff < 0) ? -w_diff : w_diff;
    w_new      = w_tgt;
    if (!sif.bypass_slew && (w_abs_diff > C_STEP)) begin
      w_new = (w_diff > 0) ? (w_cur + C_STEP) : (w_cur - C_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_clamp   <= C_CENTER;
      r_sat     <= 1'b0;
      r_buf     <= '{default: C_CENTER};
      r_wptr    <= '0;
      r_sum     <= C_SUM0;
      r_s2_vld  <= 1'b0;
      r_s3_vld  <= 1'b0;
      r_t       <= '0;
      r_steer   <= '0;
      r_out_vld <= 1'b0;
      r_settled <= 1'b1;
    end else begin
      r_s1_vld <= sif.vld;
      if (sif.vld) begin
        r_clamp <= w_clamp;
        r_sat   <= w_oor;
      end

      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_sum         <= w_sum_nxt;
        r_buf[r_wptr] <= r_clamp;
        r_wptr        <= (r_wptr == C_PLAST) ? '0 : r_wptr + PTR_W'(1);
      end

      r_s3_vld <= r_s2_vld;
      if (r_s2_vld) r_t <= w_t;

      r_out_vld <= r_s3_vld;
      if (r_s3_vld) begin
        r_steer   <= WIDTH'(w_new);
        r_settled <= (w_new == w_tgt);
      end
    end
  end

  assign sif.steer_out = r_steer;
  assign sif.out_vld   = r_out_vld;
  assign sif.sat       = r_sat;
  assign sif.settled   = r_settled;

endmodule

// File: tb/tb_steer_cond.sv
// Bench for steer_cond: directed scenarios plus random bursts, checked against
// a window-queue reference model with an in-order expectation scoreboard.
module tb_steer_cond;

  localparam int W      = 12;
  localparam int CENTER = 'h800;
  localparam int MINR   = 'h200;
  localparam int MAXR   = 'hE00;
  localparam int DEPTH  = 4;
  localparam int DB     = 16;
  localparam int STEP   = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  steer_if #(.WIDTH(W)) sif ();

  steer_cond dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  typedef struct {
    int due;
    int steer;
    bit settled;
    bit chk_sat;
    bit sat;
  } exp_t;

  exp_t expq[$];
  int   hist[$];
  int   m_out;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   mon_on = 1'b0;
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back(CENTER);
    m_out = 0;
  endfunction

  function automatic int steer_now();
    return int'($signed(sif.steer_out));
  endfunction

  // Drive one sample (called just after a rising edge) and record what should come out
  task automatic send(input int raw, input bit en, input bit byp, input bit chk_sat);
    int c, sum, avg, d, t, tgt, diff;
    bit s;
    sif.vld = 1'b1; sif.raw = W'(raw); sif.en = en; sif.bypass_slew = byp;
    s = (raw < MINR) || (raw > MAXR);
    c = (raw < MINR) ? MINR : ((raw > MAXR) ? MAXR : raw);
    void'(hist.pop_front());
    hist.push_back(c);
    sum = 0;
    foreach (hist[i]) sum += hist[i];
    avg  = sum / DEPTH;
    d    = avg - CENTER;
    t    = (d >= -DB && d <= DB) ? 0 : d;
    tgt  = en ? t : 0;
    diff = tgt - m_out;
    if (byp || (diff <= STEP && diff >= -STEP)) m_out = tgt;
    else if (diff > 0) m_out = m_out + STEP;
    else m_out = m_out - STEP;
    expq.push_back('{due: cyc + 4, steer: m_out, settled: (m_out == tgt), chk_sat: chk_sat, sat: s});
    @(posedge clk); #1;
    sif.vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One sample every 16 clocks
  task automatic spend(input int raw, input bit en, input bit byp, input int n);
    repeat (n) begin
      send(raw, en, byp, 1'b1);
      idle(15);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sif.vld = 1'b0;
    expq.delete();
    model_reset();
    idle(2);
    check("rst_steer_out", steer_now(), 0);
    check("rst_out_vld", int'(sif.out_vld), 0);
    check("rst_sat", int'(sif.sat), 0);
    check("rst_settled", int'(sif.settled), 1);
    rst_n = 1'b1;
  endtask

  // Scoreboard: out_vld only when something is due, then compare against the model
  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      if (expq.size() > 0 && expq[0].due < cyc) begin
        e = expq.pop_front();
        check("latency", cyc, e.due);
      end
      if (expq.size() > 0 && expq[0].due == cyc) begin
        e = expq.pop_front();
        check("out_vld", int'(sif.out_vld), 1);
        check("steer_out", steer_now(), e.steer);
        check("settled", int'(sif.settled), int'(e.settled));
        if (e.chk_sat) check("sat", int'(sif.sat), int'(e.sat));
      end else begin
        check("out_vld_idle", int'(sif.out_vld), 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, %0d checks made", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    int len;
    bit en, byp;
    sif.vld = 1'b0; sif.raw = '0; sif.en = 1'b0; sif.bypass_slew = 1'b0;
    model_reset();
    idle(3);
    check("init_steer_out", steer_now(), 0);
    check("init_settled", int'(sif.settled), 1);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    idle(2);

    // Reset with the pipeline full, then a centred sample leaves steering at 0
    send('hE00, 1'b1, 1'b1, 1'b0);
    send('hE00, 1'b1, 1'b1, 1'b0);
    send('hE00, 1'b1, 1'b1, 1'b0);
    do_reset();
    spend('h800, 1'b1, 1'b0, 1);
    check("t1_centre", steer_now(), 0);

    // Full right, slew-limited ramp to 1536
    spend('hE00, 1'b1, 1'b0, 26);
    check("t2_final", steer_now(), 1536);
    check("t2_settled", int'(sif.settled), 1);

    // Over-range sample is clamped and flagged
    spend('hF00, 1'b1, 1'b0, 3);
    check("t3_sat", int'(sif.sat), 1);
    check("t3_hold", steer_now(), 1536);
    spend('hA00, 1'b1, 1'b0, 30);
    check("t3_unsat", int'(sif.sat), 0);
    check("t3_final", steer_now(), 512);

    // Deadband edges, then full left with bypass
    spend('h80F, 1'b1, 1'b0, 20);
    check("t4_db15", steer_now(), 0);
    spend('h810, 1'b1, 1'b1, 4);
    check("t4_db16", steer_now(), 0);
    spend('h811, 1'b1, 1'b1, 4);
    check("t4_db17", steer_now(), 17);
    spend('h200, 1'b1, 1'b1, 4);
    check("t4_left", steer_now(), -1536);

    // Disable ramps to zero, re-enable resumes
    spend('hE00, 1'b1, 1'b0, 52);
    check("t5_start", steer_now(), 1536);
    spend('hE00, 1'b0, 1'b0, 24);
    check("t5_off", steer_now(), 0);
    spend('hE00, 1'b1, 1'b0, 5);
    check("t5_resume", steer_now(), 320);

    // Back-to-back samples, one output per cycle
    spend('h800, 1'b1, 1'b1, 4);
    send('h800, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send('hE00, 1'b1, 1'b1, i == 3);
    idle(8);
    check("t6_final", steer_now(), 1536);

    // Random bursts; en/bypass only change once the pipeline has drained
    for (int b = 0; b < 150; b++) begin
      en  = ($urandom_range(0, 3) != 0);
      byp = $urandom_range(0, 1) != 0;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        send($urandom_range(0, 4095), en, byp, k == len - 1);
      end
      if ($urandom_range(0, 19) == 0) do_reset();
      idle(4);
    end

    idle(8);
    check("drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
